// File: rtl/mem_arbiter_if.sv
// IF/MM requester ports plus the byte-wide RAM port of the memory arbiter.
// slave is the arbiter's view of the bus; master is the requester/RAM side.
interface mem_arbiter_if #(
  parameter int ADDR_W = 17
);
  logic              if_req;
  logic [31:0]       if_addr;
  logic [31:0]       if_data;
  logic              if_done;
  logic              mm_req;
  logic              mm_we;
  logic [1:0]        mm_width;
  logic              mm_sign;
  logic [31:0]       mm_addr;
  logic [31:0]       mm_wdata;
  logic [31:0]       mm_rdata;
  logic              mm_done;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_wr;
  logic [7:0]        ram_din;
  logic [7:0]        ram_dout;

  modport slave (
    input  if_req, if_addr, mm_req, mm_we, mm_width, mm_sign, mm_addr, mm_wdata, ram_dout,
    output if_data, if_done, mm_rdata, mm_done, ram_addr, ram_wr, ram_din
  );

  modport master (
    output if_req, if_addr, mm_req, mm_we, mm_width, mm_sign, mm_addr, mm_wdata, ram_dout,
    input  if_data, if_done, mm_rdata, mm_done, ram_addr, ram_wr, ram_din
  );
endinterface

// File: rtl/mem_arbiter.sv
// Serialises IF/MM requests onto one byte RAM port; MM wins; done = N+1 cycles (write) / N+2 (read).
// Requesters hold req until their done pulse; nothing is sampled while a transaction is in flight.
module mem_arbiter #(
  parameter int ADDR_W = 17
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_CAPT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [1:0]        k_q, k_d;
  logic [1:0]        last_q, last_d;
  logic              own_mm_q, own_mm_d;
  logic              we_q, we_d;
  logic              sign_q, sign_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rd_q, rd_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              ram_wr_q, ram_wr_d;
  logic [7:0]        ram_din_q, ram_din_d;
  logic [31:0]       if_data_q, if_data_d;
  logic [31:0]       mm_rdata_q, mm_rdata_d;
  logic              if_done_q, if_done_d;
  logic              mm_done_q, mm_done_d;

  logic              acc_mm;
  logic [ADDR_W-1:0] acc_addr;
  logic [1:0]        k_nx;
  logic [ADDR_W-1:0] addr_nx;
  logic [31:0]       rd_fin;

  // last_q holds N-1: 0 byte, 1 half, 3 word
  function automatic logic [31:0] extend(input logic [31:0] v, input logic [1:0] last,
                                         input logic sgn);
    case (last)
      2'd0:    extend = {{24{sgn & v[7]}}, v[7:0]};
      2'd1:    extend = {{16{sgn & v[15]}}, v[15:0]};
      default: extend = v;
    endcase
  endfunction

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    last_d     = last_q;
    own_mm_d   = own_mm_q;
    we_d       = we_q;
    sign_d     = sign_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_d       = rd_q;
    ram_addr_d = ram_addr_q;
    ram_wr_d   = 1'b0;
    ram_din_d  = ram_din_q;
    if_data_d  = if_data_q;
    mm_rdata_d = mm_rdata_q;
    if_done_d  = 1'b0;
    mm_done_d  = 1'b0;

    acc_mm   = bus.mm_req;
    acc_addr = acc_mm ? bus.mm_addr[ADDR_W-1:0] : bus.if_addr[ADDR_W-1:0];
    k_nx     = k_q + 2'd1;
    // only the low ADDR_W bits of addr+k ever reach the RAM, so 2^32 wrap is implied
    addr_nx  = addr_q + ADDR_W'(k_nx);
    rd_fin   = rd_q;
    rd_fin[{last_q, 3'b000} +: 8] = bus.ram_dout;

    case (state_q)
      S_IDLE: begin
        if (bus.mm_req || bus.if_req) begin
          state_d    = S_ISSUE;
          k_d        = 2'd0;
          own_mm_d   = acc_mm;
          we_d       = acc_mm & bus.mm_we;
          sign_d     = acc_mm & bus.mm_sign;
          last_d     = !acc_mm ? 2'd3 :
                       (bus.mm_width == 2'b00) ? 2'd0 :
                       (bus.mm_width == 2'b01) ? 2'd1 : 2'd3;
          addr_d     = acc_addr;
          wdata_d    = bus.mm_wdata;
          rd_d       = 32'd0;
          ram_addr_d = acc_addr;
          ram_wr_d   = acc_mm & bus.mm_we;
          if (acc_mm && bus.mm_we) ram_din_d = bus.mm_wdata[7:0];
        end
      end
      S_ISSUE: begin
        // RAM answers one cycle after the address, so byte k-1 lands now
        if (!we_q && k_q != 2'd0) rd_d[{k_q - 2'd1, 3'b000} +: 8] = bus.ram_dout;
        if (k_q == last_q) begin
          state_d   = we_q ? S_DONE : S_CAPT;
          mm_done_d = we_q;
        end else begin
          k_d        = k_nx;
          ram_addr_d = addr_nx;
          ram_wr_d   = we_q;
          if (we_q) ram_din_d = wdata_q[{k_nx, 3'b000} +: 8];
        end
      end
      S_CAPT: begin
        rd_d    = rd_fin;
        state_d = S_DONE;
        if (own_mm_q) begin
          mm_rdata_d = extend(rd_fin, last_q, sign_q);
          mm_done_d  = 1'b1;
        end else begin
          if_data_d = rd_fin;
          if_done_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      k_q        <= 2'd0;
      last_q     <= 2'd0;
      own_mm_q   <= 1'b0;
      we_q       <= 1'b0;
      sign_q     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= 32'd0;
      rd_q       <= 32'd0;
      ram_addr_q <= '0;
      ram_wr_q   <= 1'b0;
      ram_din_q  <= 8'd0;
      if_data_q  <= 32'd0;
      mm_rdata_q <= 32'd0;
      if_done_q  <= 1'b0;
      mm_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      last_q     <= last_d;
      own_mm_q   <= own_mm_d;
      we_q       <= we_d;
      sign_q     <= sign_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rd_q       <= rd_d;
      ram_addr_q <= ram_addr_d;
      ram_wr_q   <= ram_wr_d;
      ram_din_q  <= ram_din_d;
      if_data_q  <= if_data_d;
      mm_rdata_q <= mm_rdata_d;
      if_done_q  <= if_done_d;
      mm_done_q  <= mm_done_d;
    end
  end

  assign bus.ram_addr = ram_addr_q;
  assign bus.ram_wr   = ram_wr_q;
  assign bus.ram_din  = ram_din_q;
  assign bus.if_data  = if_data_q;
  assign bus.if_done  = if_done_q;
  assign bus.mm_rdata = mm_rdata_q;
  assign bus.mm_done  = mm_done_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed table, reset/priority sequences and randomized traffic
// against a byte-array memory model; synchronous 1-cycle-latency RAM modelled here.
module tb_mem_arbiter;
  localparam int ADDR_W = 17;
  localparam int MEM_SZ = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();
  mem_arbiter #(.ADDR_W(ADDR_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [7:0] mem     [MEM_SZ];
  logic [7:0] ref_mem [MEM_SZ];

  always @(posedge clk) begin
    bus.ram_dout <= mem[bus.ram_addr];
    if (bus.ram_wr) mem[bus.ram_addr] = bus.ram_din;
  end

  int nvec = 0;
  int nmis = 0;

  typedef struct {
    bit          is_if;
    bit          we;
    logic [1:0]  width;
    bit          sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl [15];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic poke(input logic [31:0] a, input logic [7:0] v);
    mem[a[ADDR_W-1:0]]     = v;
    ref_mem[a[ADDR_W-1:0]] = v;
  endtask

  function automatic int nbytes(input logic [1:0] w);
    return (w == 2'b00) ? 1 : (w == 2'b01) ? 2 : 4;
  endfunction

  // little-endian assembly of n bytes, then two's-complement reinterpretation when signed
  function automatic logic [31:0] model_read(input logic [31:0] addr, input int n, input bit sgn);
    longint      v = 0;
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      a = addr + 32'(i);
      v += longint'(ref_mem[a[ADDR_W-1:0]]) << (8 * i);
    end
    if (sgn && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, " ram_addr"}, 32'(bus.ram_addr), 32'd0);
    check({tag, " ram_wr"},   32'(bus.ram_wr),   32'd0);
    check({tag, " ram_din"},  32'(bus.ram_din),  32'd0);
    check({tag, " if_data"},  bus.if_data,       32'd0);
    check({tag, " if_done"},  32'(bus.if_done),  32'd0);
    check({tag, " mm_rdata"}, bus.mm_rdata,      32'd0);
    check({tag, " mm_done"},  32'(bus.mm_done),  32'd0);
  endtask

  // Called at a negedge with the arbiter idle; returns at the negedge of the cycle after done.
  task automatic run_txn(input bit is_if, input bit we, input logic [1:0] width, input bit sgn,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_data, input bit early);
    int          n  = is_if ? 4 : nbytes(width);
    bit          wr = !is_if && we;
    int          dc = wr ? n + 1 : n + 2;
    logic [31:0] a;
    logic [31:0] sh;
    if (is_if) begin
      bus.if_addr = addr;
      bus.if_req  = 1'b1;
    end else begin
      bus.mm_we    = we;
      bus.mm_width = width;
      bus.mm_sign  = sgn;
      bus.mm_addr  = addr;
      bus.mm_wdata = wdata;
      bus.mm_req   = 1'b1;
    end
    if (wr) begin
      for (int k = 0; k < n; k++) begin
        a  = addr + 32'(k);
        sh = wdata >> (8 * k);
        ref_mem[a[ADDR_W-1:0]] = sh[7:0];
      end
    end
    @(posedge clk);
    for (int c = 1; c <= dc + 1; c++) begin
      @(negedge clk);
      if (c == 1 && early) begin
        if (is_if) begin
          bus.if_req  = 1'b0;
          bus.if_addr = $urandom;
        end else begin
          bus.mm_req   = 1'b0;
          bus.mm_addr  = $urandom;
          bus.mm_wdata = $urandom;
          bus.mm_width = 2'($urandom_range(0, 3));
          bus.mm_sign  = 1'($urandom_range(0, 1));
          bus.mm_we    = 1'($urandom_range(0, 1));
        end
      end
      check($sformatf("@%h c%0d ram_wr", addr, c), 32'(bus.ram_wr), 32'(wr && c <= n));
      if (c <= n) begin
        a = addr + 32'(c - 1);
        check($sformatf("@%h c%0d ram_addr", addr, c), 32'(bus.ram_addr), 32'(a[ADDR_W-1:0]));
        if (wr) begin
          sh = wdata >> (8 * (c - 1));
          check($sformatf("@%h c%0d ram_din", addr, c), 32'(bus.ram_din), 32'(sh[7:0]));
        end
      end
      check($sformatf("@%h c%0d if_done", addr, c), 32'(bus.if_done), 32'(is_if && c == dc));
      check($sformatf("@%h c%0d mm_done", addr, c), 32'(bus.mm_done), 32'(!is_if && c == dc));
      if (c == dc && !wr) begin
        if (is_if) check($sformatf("@%h if_data", addr), bus.if_data, exp_data);
        else       check($sformatf("@%h mm_rdata", addr), bus.mm_rdata, exp_data);
      end
      if (c == dc) begin
        if (is_if) bus.if_req = 1'b0;
        else       bus.mm_req = 1'b0;
      end
    end
  endtask

  initial begin
    logic [31:0] ra, ifa, wd, ex;
    logic [1:0]  rw;
    bit          ris_if, rwe, rsg, both, early;
    int          bad;

    bus.if_req = 1'b0; bus.if_addr = 32'd0;
    bus.mm_req = 1'b0; bus.mm_we = 1'b0; bus.mm_width = 2'd0; bus.mm_sign = 1'b0;
    bus.mm_addr = 32'd0; bus.mm_wdata = 32'd0;
    for (int i = 0; i < MEM_SZ; i++) begin
      ra = $urandom;
      mem[i]     = ra[7:0];
      ref_mem[i] = ra[7:0];
    end
    poke(32'h100, 8'h11); poke(32'h101, 8'h22); poke(32'h102, 8'h33); poke(32'h103, 8'h44);
    poke(32'h7, 8'h80);
    poke(32'h20, 8'h5A); poke(32'h21, 8'h5A); poke(32'h22, 8'h5A);
    poke(32'h30, 8'h99);
    poke(32'h1FFFE, 8'hA1); poke(32'h1FFFF, 8'hB2);
    poke(32'h0, 8'hC3); poke(32'h1, 8'hD4); poke(32'h2, 8'hE5);
    poke(32'h10, 8'h01); poke(32'h11, 8'h02); poke(32'h12, 8'h03); poke(32'h13, 8'h04);

    tbl[0]  = '{1'b1, 1'b0, 2'd2, 1'b0, 32'h100,      32'h0,        32'h44332211};
    tbl[1]  = '{1'b0, 1'b0, 2'd0, 1'b1, 32'h7,        32'h0,        32'hFFFFFF80};
    tbl[2]  = '{1'b0, 1'b0, 2'd0, 1'b0, 32'h7,        32'h0,        32'h00000080};
    tbl[3]  = '{1'b0, 1'b1, 2'd1, 1'b0, 32'h20,       32'hDEADBEEF, 32'h0};
    tbl[4]  = '{1'b0, 1'b0, 2'd1, 1'b1, 32'h20,       32'h0,        32'hFFFFBEEF};
    tbl[5]  = '{1'b0, 1'b0, 2'd1, 1'b0, 32'h20,       32'h0,        32'h0000BEEF};
    tbl[6]  = '{1'b0, 1'b0, 2'd3, 1'b1, 32'h100,      32'h0,        32'h44332211};
    tbl[7]  = '{1'b0, 1'b0, 2'd2, 1'b0, 32'h1FFFE,    32'h0,        32'hD4C3B2A1};
    tbl[8]  = '{1'b0, 1'b1, 2'd0, 1'b0, 32'h30,       32'h12345678, 32'h0};
    tbl[9]  = '{1'b0, 1'b0, 2'd0, 1'b1, 32'h30,       32'h0,        32'h00000078};
    tbl[10] = '{1'b0, 1'b0, 2'd2, 1'b1, 32'hFFFFFFFF, 32'h0,        32'hE5D4C3B2};
    tbl[11] = '{1'b0, 1'b1, 2'd2, 1'b0, 32'h50,       32'hCAFEF00D, 32'h0};
    tbl[12] = '{1'b0, 1'b0, 2'd2, 1'b1, 32'h50,       32'h0,        32'hCAFEF00D};
    tbl[13] = '{1'b1, 1'b0, 2'd0, 1'b0, 32'h1FFFF,    32'h0,        32'hE5D4C3B2};
    tbl[14] = '{1'b0, 1'b0, 2'd1, 1'b1, 32'h1FFFF,    32'h0,        32'hFFFFC3B2};

    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b1;

    for (int i = 0; i < 15; i++)
      run_txn(tbl[i].is_if, tbl[i].we, tbl[i].width, tbl[i].sgn, tbl[i].addr,
              tbl[i].wdata, tbl[i].exp, 1'b0);
    check("half write spares 0x22", 32'(mem[32'h22]), 32'h5A);

    // both requesters rise together: MM word write first, then IF in the next idle cycle
    bus.if_addr = 32'h100;
    bus.if_req  = 1'b1;
    run_txn(1'b0, 1'b1, 2'd2, 1'b0, 32'h40, 32'h87654321, 32'h0, 1'b0);
    run_txn(1'b1, 1'b0, 2'd0, 1'b0, 32'h100, 32'h0, 32'h44332211, 1'b0);

    // reset lands while the third byte of a word write is on the bus
    bus.mm_we = 1'b1; bus.mm_width = 2'd2; bus.mm_sign = 1'b0;
    bus.mm_addr = 32'h10; bus.mm_wdata = 32'hA1B2C3D4; bus.mm_req = 1'b1;
    @(posedge clk);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check_idle_outputs("mid-reset");
    bus.mm_req = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("mm_done in reset", 32'(bus.mm_done), 32'd0);
    end
    check("aborted RAM[0x10]", 32'(mem[32'h10]), 32'hD4);
    check("aborted RAM[0x11]", 32'(mem[32'h11]), 32'hC3);
    check("aborted RAM[0x12]", 32'(mem[32'h12]), 32'h03);
    check("aborted RAM[0x13]", 32'(mem[32'h13]), 32'h04);
    ref_mem[32'h10] = 8'hD4;
    ref_mem[32'h11] = 8'hC3;
    rst = 1'b1;
    run_txn(1'b1, 1'b0, 2'd0, 1'b0, 32'h10, 32'h0, 32'h0403C3D4, 1'b0);

    for (int it = 0; it < 60; it++) begin
      both   = ($urandom_range(0, 3) == 0);
      ris_if = ($urandom_range(0, 2) == 0) && !both;
      rwe    = 1'($urandom_range(0, 1));
      rw     = 2'($urandom_range(0, 3));
      rsg    = 1'($urandom_range(0, 1));
      early  = 1'($urandom_range(0, 1));
      ra     = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 63));
      wd     = $urandom;
      ifa    = $urandom;
      if (both) begin
        bus.if_addr = ifa;
        bus.if_req  = 1'b1;
      end
      ex = (ris_if || !rwe) ? model_read(ra, ris_if ? 4 : nbytes(rw), ris_if ? 1'b0 : rsg)
                            : 32'h0;
      run_txn(ris_if, rwe, rw, rsg, ra, wd, ex, early);
      if (both) run_txn(1'b1, 1'b0, 2'd0, 1'b0, ifa, 32'h0, model_read(ifa, 4, 1'b0), 1'b0);
    end

    bad = 0;
    for (int i = 0; i < MEM_SZ; i++) if (mem[i] !== ref_mem[i]) bad++;
    check("memory image byte errors", 32'(bad), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Arbitrates the single byte-wide RAM port between the instruction-fetch stage (IF) and the memory-access stage (MM) of the 5-stage pipeline. Each accepted request is serialised into 1, 2 or 4 byte transactions, little-endian. Requesters hold req until a one-cycle done pulse arrives; the pipeline stalls on a pending, not-yet-done request. MM always has priority over IF; an accepted transaction is never pre-empted.

Parameters:
ADDR_W, 17, width of ram_addr; the low ADDR_W bits of the byte address are driven.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
if_req  in  1  IF read request (level, word-sized)
if_addr  in  32  IF byte address
if_data  out  32  fetched word, valid only while if_done=1
if_done  out  1  one-cycle completion pulse for IF
mm_req  in  1  MM request (level)
mm_we  in  1  1=write, 0=read
mm_width  in  2  00=byte, 01=half, 10=word; 11 is treated as word
mm_sign  in  1  read result sign-extended when 1, zero-extended when 0
mm_addr  in  32  MM byte address
mm_wdata  in  32  write data; low bytes used per width
mm_rdata  out  32  extended read data, valid only while mm_done=1
mm_done  out  1  one-cycle completion pulse for MM
ram_addr  out  ADDR_W  RAM byte address
ram_wr  out  1  RAM write strobe
ram_din  out  8  byte written to RAM
ram_dout  in  8  byte read from RAM; 1-cycle latency after ram_addr

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; byte counter 0; ram_addr, ram_din, if_data and mm_rdata all 0; ram_wr, if_done and mm_done all 0. An in-flight transaction is abandoned with no done pulse and no further RAM writes.
- States: IDLE, ISSUE, CAPT (read only), DONE. All outputs are registered.
- IDLE: on a clock edge, if mm_req=1, latch the MM request. Otherwise, if if_req=1, latch the IF request as a word read. Otherwise stay in IDLE. Latching moves the state to ISSUE with counter k=0.
  - N (bytes) = 1, 2 or 4 from the width. IF is always N=4.
  - The edge at which IDLE samples the request is the acceptance edge. Cycle 1 is the cycle after it.
- ISSUE, cycle 1+k: ram_addr = (addr+k) mod 2^32, low ADDR_W bits.
  - Write: ram_wr=1 and ram_din = wdata[8k+7:8k].
  - Read: ram_wr=0. The byte for k-1 (k≥1) is captured from ram_dout into bits [8(k-1)+7:8(k-1)].
  - After k=N-1: a write goes to DONE; a read goes to CAPT.
- CAPT, cycle N+1: capture the last byte; ram_wr=0. Next state is DONE.
- DONE: the done pulse of the owning requester is 1 for exactly one cycle, and the read data is valid in that cycle.
  - Word read: done in cycle N+2 = 6. Byte read: done in cycle 3.
  - Word write: done in cycle N+1 = 5. Byte write: done in cycle 2.
  - DONE always returns to IDLE, and no request is sampled during DONE. A requester must drop req in the cycle after done, or a new transaction is started.
- Extension of mm_rdata:
  - byte: bits[31:8] = mm_sign ? bit7 : 0.
  - half: bits[31:16] = mm_sign ? bit15 : 0.
  - word: unmodified.
  - if_data is never extended.
- Outside ISSUE, ram_wr=0. ram_addr and ram_din hold their last value.
- req deasserted mid-transaction is ignored: the transaction, including all write bytes, completes and done still pulses.
- Address wrap: 0xFFFFFFFF+1 wraps to 0. Misaligned addresses are legal; bytes are issued sequentially.
- Simultaneous if_req and mm_req in IDLE: MM is served first. IF is served in the next IDLE in which mm_req=0.
- Inputs (addr, wdata, width, sign, we) are latched at acceptance. Changes afterwards have no effect.

Test Plan:
- Reset then IF word read, addr 0x100, RAM[0x100..0x103]=11,22,33,44 -> ram_addr 0x100..0x103 in cycles 1-4; if_done=1 only in cycle 6 with if_data=0x44332211.
- MM signed byte read, addr 0x7, RAM[7]=0x80 -> mm_done in cycle 3, mm_rdata=0xFFFFFF80. With mm_sign=0 -> 0x00000080.
- MM half write, wdata=0xDEADBEEF, addr 0x20 -> ram_wr=1 in cycles 1-2 only, with (0x20,0xEF) then (0x21,0xBE); mm_done in cycle 3; RAM[0x22] untouched.
- if_req and mm_req (word write, addr 0x40) both rise in the same cycle -> MM runs first with mm_done in cycle 5; IF is accepted in the following IDLE and if_done follows 6 cycles after that acceptance; no byte interleaving.
- Word write to 0x10; rst=0 after 2 bytes -> all outputs are 0 immediately; RAM[0x12], RAM[0x13] are unwritten; no mm_done; a clean IF read succeeds after reset is released.
- ADDR_W=17, MM word read at 0x1FFFE -> ram_addr sequence 0x1FFFE, 0x1FFFF, 0x00000, 0x00001.
